// File: rtl/sample_load_sequencer.sv
// Sample-buffer load sequencer between the HPS PIO link and the chromosome processing engine.
// Optional SAMPLE_CHECKSUM_EN adds a running checksum output over accepted words.
module sample_load_sequencer #(
    parameter int NUM_WORDS = 8,
    parameter int SAMPLE_W  = 8
) (
    input  logic                              iClock,
    input  logic                              iReset_n,
    input  logic                              iWriteSample,
    input  logic [31:0]                       iSampleIndex,
    input  logic [31:0]                       iInputWord,
    input  logic [31:0]                       iExpectedWord,
    input  logic [31:0]                       iValidWord,
    input  logic                              iClear,
    input  logic                              iStartRequest,
    input  logic                              iReadyToProcess,
    input  logic                              iDoneProcessing,
    output logic                              oNextSample,
    output logic                              oPreparingNextSample,
    output logic [4*NUM_WORDS*SAMPLE_W-1:0]   oInputSequences,
    output logic [4*NUM_WORDS*SAMPLE_W-1:0]   oExpectedOutputs,
    output logic [4*NUM_WORDS*SAMPLE_W-1:0]   oValidOutputs,
    output logic [7:0]                        oSequencesToProcess,
    output logic                              oStartProcessing,
    output logic                              oDone,
    output logic                              oIndexError,
    output logic [2:0]                        oState
`ifdef SAMPLE_CHECKSUM_EN
    ,
    output logic [31:0]                       oChecksum
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LATCH    = 3'd1;
    localparam logic [2:0] S_ACK      = 3'd2;
    localparam logic [2:0] S_WAIT_RDY = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [NUM_WORDS-1:0] mask;
    logic [NUM_WORDS-1:0] next_mask;
    logic [7:0]           next_seq;
    logic                 idx_ok;

    assign idx_ok = (iSampleIndex < 32'(NUM_WORDS));

    always_comb begin
        next_mask = mask;
        if (state == S_LATCH && idx_ok) begin
            for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                if (iSampleIndex == w) next_mask[w] = 1'b1;
            end
        end
    end

    // Highest loaded word wins; later iterations overwrite lower ones.
    always_comb begin
        next_seq = '0;
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
            if (next_mask[w]) next_seq = 8'(4 * (w + 1));
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (iWriteSample)                       next_state = S_LATCH;
                else if (iStartRequest && (mask != '0)) next_state = S_WAIT_RDY;
            end
            S_LATCH:    next_state = S_ACK;
            S_ACK:      if (!iWriteSample) next_state = S_IDLE;
            S_WAIT_RDY: begin
                if (!iStartRequest)       next_state = S_IDLE;
                else if (iReadyToProcess) next_state = S_RUN;
            end
            S_RUN:      if (iDoneProcessing) next_state = S_DONE;
            S_DONE:     if (!iStartRequest) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state               <= S_IDLE;
            mask                <= '0;
            oSequencesToProcess <= '0;
            oIndexError         <= 1'b0;
            oInputSequences     <= '0;
            oExpectedOutputs    <= '0;
            oValidOutputs       <= '0;
`ifdef SAMPLE_CHECKSUM_EN
            oChecksum           <= '0;
`endif
        end else begin
            state <= next_state;
            if (state == S_IDLE && iClear) begin
                mask                <= '0;
                oSequencesToProcess <= '0;
                oIndexError         <= 1'b0;
`ifdef SAMPLE_CHECKSUM_EN
                oChecksum           <= '0;
`endif
            end else if (state == S_LATCH) begin
                mask                <= next_mask;
                oSequencesToProcess <= next_seq;
                if (!idx_ok) begin
                    oIndexError <= 1'b1;
                end else begin
                    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
                        if (iSampleIndex == w) begin
                            for (int unsigned l = 0; l < 4; l++) begin
                                oInputSequences[(4*w+l)*SAMPLE_W +: SAMPLE_W]  <= iInputWord[8*l +: SAMPLE_W];
                                oExpectedOutputs[(4*w+l)*SAMPLE_W +: SAMPLE_W] <= iExpectedWord[8*l +: SAMPLE_W];
                                oValidOutputs[(4*w+l)*SAMPLE_W +: SAMPLE_W]    <= iValidWord[8*l +: SAMPLE_W];
                            end
                        end
                    end
`ifdef SAMPLE_CHECKSUM_EN
                    oChecksum <= {oChecksum[30:0], oChecksum[31]} ^ iInputWord ^ iExpectedWord ^ iValidWord;
`endif
                end
            end
        end
    end

    assign oNextSample          = (state == S_ACK);
    assign oStartProcessing     = (state == S_RUN);
    assign oDone                = (state == S_DONE);
    assign oPreparingNextSample = (state == S_LATCH) || (state == S_WAIT_RDY) ||
                                  (state == S_RUN)   || (state == S_DONE);
    assign oState               = state;

endmodule
